// File: rtl/csla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : csla_pipe_adder
//  Description : Parametrised pipelined carry-select adder/subtractor with
//                valid/ready handshake on both sides. Every carry-select
//                block gets two candidate sums (block carry-in 0 and 1) when
//                the operands are accepted. Each pipeline stage then resolves
//                one block, using the carry-out of the block below it.
//                Optional flags (Zero, Ovf) are built only when the macro
//                CSLA_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module csla_pipe_adder #(
    parameter int WIDTH = 32,   // operand width, multiple of BLK
    parameter int BLK   = 8     // carry-select block width
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef CSLA_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Ovf
`endif
);

    localparam int         NBLK  = WIDTH / BLK;
    localparam logic [BLK:0] C_ONE = {{BLK{1'b0}}, 1'b1};

    // One (BLK+1)-bit candidate sum per block, packed block-major.
    typedef logic [NBLK-1:0][BLK:0] cand_t;

    // ------------------------------------------------------------------
    // Operand conditioning and candidate generation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bx;      // B, or ~B when subtracting
    logic             w_c0;      // carry into block 0
    cand_t            w_cand0;   // per-block sum with block carry-in 0
    cand_t            w_cand1;   // per-block sum with block carry-in 1
    logic             w_en;      // global pipeline advance

    assign w_bx = Sub ? ~B : B;
    assign w_c0 = Sub ? ~Cin : Cin;

    for (genvar i = 0; i < NBLK; i++) begin : g_cand
        assign w_cand0[i] = {1'b0, A[i*BLK +: BLK]} + {1'b0, w_bx[i*BLK +: BLK]};
        // The carry-in-1 sum cannot exceed 2^(BLK+1)-1, so it fits BLK+1 bits.
        assign w_cand1[i] = w_cand0[i] + C_ONE;
    end

    // ------------------------------------------------------------------
    // Pipeline stage state. Index k holds the stage that has resolved
    // blocks 0..k. The remaining candidates travel along unchanged.
    // ------------------------------------------------------------------
    logic [NBLK-1:0]  valid_q, valid_d;
    logic [NBLK-1:0]  carry_q, carry_d;
    logic [WIDTH-1:0] sum_q   [NBLK];
    logic [WIDTH-1:0] sum_d   [NBLK];
    cand_t            cand0_q [NBLK];
    cand_t            cand0_d [NBLK];
    cand_t            cand1_q [NBLK];
    cand_t            cand1_d [NBLK];
    logic [BLK:0]     w_sel   [NBLK];   // selected candidate per stage

`ifdef CSLA_FLAGS_EN
    // a_msb ^ bx_msb is carried along so the output stage can recover the
    // carry into the MSB from the resolved sum bit.
    logic [NBLK-1:0]  px_q, px_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    // Stalls freeze everything. A free output slot lets all stages shift.
    assign w_en     = Out_Ready | ~valid_q[NBLK-1];
    assign In_Ready = w_en;

    // Next-state for every stage: resolve one block and pass the rest on.
    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            w_sel[k]   = '0;
            sum_d[k]   = '0;
            cand0_d[k] = '0;
            cand1_d[k] = '0;
        end
        valid_d = '0;
        carry_d = '0;

        // Stage 0 takes the operands directly and resolves block 0 with c0.
        w_sel[0]            = w_c0 ? w_cand1[0] : w_cand0[0];
        valid_d[0]          = In_Valid;
        carry_d[0]          = w_sel[0][BLK];
        sum_d[0][BLK-1:0]   = w_sel[0][BLK-1:0];
        cand0_d[0]          = w_cand0;
        cand1_d[0]          = w_cand1;

        // Stage k resolves block k using the carry-out from stage k-1.
        for (int k = 1; k < NBLK; k++) begin
            w_sel[k]                 = carry_q[k-1] ? cand1_q[k-1][k] : cand0_q[k-1][k];
            valid_d[k]               = valid_q[k-1];
            carry_d[k]               = w_sel[k][BLK];
            sum_d[k]                 = sum_q[k-1];
            sum_d[k][k*BLK +: BLK]   = w_sel[k][BLK-1:0];
            cand0_d[k]               = cand0_q[k-1];
            cand1_d[k]               = cand1_q[k-1];
        end
    end

`ifdef CSLA_FLAGS_EN
    // Flags are computed from the value entering the output stage.
    always_comb begin
        px_d    = '0;
        px_d[0] = A[WIDTH-1] ^ w_bx[WIDTH-1];
        for (int k = 1; k < NBLK; k++) begin
            px_d[k] = px_q[k-1];
        end
        zero_d = (sum_d[NBLK-1] == '0);
        // carry into MSB = s_msb ^ a_msb ^ bx_msb; overflow = that ^ carry out
        ovf_d  = sum_d[NBLK-1][WIDTH-1] ^ px_d[NBLK-1] ^ carry_d[NBLK-1];
    end
`endif

    // Stage registers: asynchronous clear, shift only on global advance.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < NBLK; k++) begin
                sum_q[k]   <= '0;
                cand0_q[k] <= '0;
                cand1_q[k] <= '0;
            end
        end else if (w_en) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < NBLK; k++) begin
                sum_q[k]   <= sum_d[k];
                cand0_q[k] <= cand0_d[k];
                cand1_q[k] <= cand1_d[k];
            end
        end
    end

`ifdef CSLA_FLAGS_EN
    // Flag registers sit in the output stage and stall with S.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            px_q   <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (w_en) begin
            px_q   <= px_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Zero = zero_q;
    assign Ovf  = ovf_q;
`endif

    // Already-resolved candidates are kept only for pipeline regularity.
    // The synthesiser prunes them. This sink keeps them from showing up
    // as dangling.
    logic w_unused;
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            w_unused = w_unused ^ (^cand0_q[k]) ^ (^cand1_q[k]);
        end
`ifdef CSLA_FLAGS_EN
        w_unused = w_unused ^ px_q[NBLK-1];
`endif
    end

    // The output stage is the last pipeline stage.
    assign S         = sum_q[NBLK-1];
    assign Cout      = carry_q[NBLK-1];
    assign Out_Valid = valid_q[NBLK-1];

endmodule
`default_nettype wire

// File: tb/tb_csla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csla_pipe_adder
//  Description : Self-checking bench for csla_pipe_adder. Includes a
//                32/8 scoreboarded instance plus 16/4 and 8/8 directed
//                instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csla_pipe_adder;

    localparam int W  = 32;
    localparam int BK = 8;
    localparam int NB = W / BK;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          Rst_n;
    logic          In_Valid, In_Ready, Cin, Sub, Out_Valid, Out_Ready, Cout;
    logic [W-1:0]  A, B, S;
    logic          s16_iv, s16_ir, s16_cin, s16_sub, s16_ov, s16_or, s16_co;
    logic [15:0]   s16_a, s16_b, s16_s;
    logic          s8_iv, s8_ir, s8_cin, s8_sub, s8_ov, s8_or, s8_co;
    logic [7:0]    s8_a, s8_b, s8_s;
`ifdef CSLA_FLAGS_EN
    logic          Zero, Ovf, s16_z, s16_o, s8_z, s8_o;
`endif

    csla_pipe_adder #(.WIDTH(W), .BLK(BK)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .S(S), .Cout(Cout)
`ifdef CSLA_FLAGS_EN
        , .Zero(Zero), .Ovf(Ovf)
`endif
    );

    csla_pipe_adder #(.WIDTH(16), .BLK(4)) dut16 (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(s16_iv), .In_Ready(s16_ir),
        .A(s16_a), .B(s16_b), .Cin(s16_cin), .Sub(s16_sub), .Out_Valid(s16_ov),
        .Out_Ready(s16_or), .S(s16_s), .Cout(s16_co)
`ifdef CSLA_FLAGS_EN
        , .Zero(s16_z), .Ovf(s16_o)
`endif
    );

    csla_pipe_adder #(.WIDTH(8), .BLK(8)) dut8 (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(s8_iv), .In_Ready(s8_ir),
        .A(s8_a), .B(s8_b), .Cin(s8_cin), .Sub(s8_sub), .Out_Valid(s8_ov),
        .Out_Ready(s8_or), .S(s8_s), .Cout(s8_co)
`ifdef CSLA_FLAGS_EN
        , .Zero(s8_z), .Ovf(s8_o)
`endif
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         z;
        logic         o;
        int           t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   exact_lat = 1'b1;
    bit   head_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rbit();
        int unsigned r;
        r = $urandom;
        return r[0];
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint ua, ub, ur, sa, sbv, sr, one, lim;
        one = 1;
        lim = one <<< (W - 1);
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!sub) begin
            ur  = ua + ub + longint'(cin);
            sr  = sa + sbv + longint'(cin);
            e.c = (ur >= (one <<< W));
        end else begin
            ur  = ua - ub - longint'(cin);
            sr  = sa - sbv - longint'(cin);
            e.c = (ua >= ub + longint'(cin));
        end
        e.s = ur[W-1:0];
        e.z = (e.s == '0);
        e.o = (sr > lim - 1) || (sr < -lim);
        e.t = 0;
        return e;
    endfunction

    task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit c, input bit s, input bit ordy);
        In_Valid  = v;
        A         = a;
        B         = b;
        Cin       = c;
        Sub       = s;
        Out_Ready = ordy;
    endtask

    // One clock: check the output at negedge, update the scoreboard at the edge.
    task automatic tick(output bit acc);
        bit   xfer;
        int   lat;
        exp_t e;
        @(negedge Clk);
        acc  = (In_Valid === 1'b1) && (In_Ready === 1'b1);
        xfer = (Out_Valid === 1'b1) && (Out_Ready === 1'b1);
        e    = model(A, B, Cin, Sub);
        if (Out_Valid !== 1'b0) begin
            if (sb.size() == 0) begin
                check("out_valid_without_pending", {63'd0, Out_Valid}, 64'd0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    lat = cyc - sb[0].t + 1;
                    if (exact_lat) check("latency", lat, NB);
                    else           check("latency_min", {63'd0, lat >= NB}, 64'd1);
                end
                check("S", S, sb[0].s);
                check("Cout", {63'd0, Cout}, {63'd0, sb[0].c});
`ifdef CSLA_FLAGS_EN
                check("Zero", {63'd0, Zero}, {63'd0, sb[0].z});
                check("Ovf", {63'd0, Ovf}, {63'd0, sb[0].o});
`endif
                if (xfer) begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
        @(posedge Clk);
        cyc++;
        if (acc) begin
            e.t = cyc;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        bit acc;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick(acc);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] es, input logic ec);
        int e;
        bit got;
        @(negedge Clk);
        s16_iv = 1'b1; s16_a = a; s16_b = b; s16_cin = cin; s16_sub = sub;
        @(posedge Clk);
        e = 1;
        #1 s16_iv = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (s16_ov === 1'b1) begin got = 1'b1; break; end
            @(posedge Clk);
            e++;
        end
        check("w16_result_seen", {63'd0, got}, 64'd1);
        if (got) begin
            check("w16_latency", e, 4);
            check("w16_S", s16_s, es);
            check("w16_Cout", {63'd0, s16_co}, {63'd0, ec});
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] es, input logic ec);
        int e;
        bit got;
        @(negedge Clk);
        s8_iv = 1'b1; s8_a = a; s8_b = b; s8_cin = cin; s8_sub = sub;
        @(posedge Clk);
        e = 1;
        #1 s8_iv = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (s8_ov === 1'b1) begin got = 1'b1; break; end
            @(posedge Clk);
            e++;
        end
        check("w8_result_seen", {63'd0, got}, 64'd1);
        if (got) begin
            check("w8_latency", e, 1);
            check("w8_S", s8_s, es);
            check("w8_Cout", {63'd0, s8_co}, {63'd0, ec});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        bit           vc [5];
        bit           vs [5];
        bit           acc;
        int           i, j;
        logic [W-1:0] ra, rb;
        bit           rc, rs;

        va[0] = 32'hFFFF0000; vb[0] = 32'h0000FFFF; vc[0] = 1'b1; vs[0] = 1'b0;
        va[1] = 32'd2017701177; vb[1] = 32'd1701853; vc[1] = 1'b0; vs[1] = 1'b0;
        va[2] = 32'hFFABCEDC; vb[2] = 32'hEF821EDA; vc[2] = 1'b1; vs[2] = 1'b0;
        va[3] = 32'd5;        vb[3] = 32'd7;        vc[3] = 1'b0; vs[3] = 1'b1;
        va[4] = 32'h80000000; vb[4] = 32'd1;        vc[4] = 1'b0; vs[4] = 1'b1;

        // Reset values (Out_Ready low so In_Ready=1 comes only from empty output)
        Rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        s16_iv = 1'b0; s16_a = '0; s16_b = '0; s16_cin = 1'b0; s16_sub = 1'b0; s16_or = 1'b1;
        s8_iv  = 1'b0; s8_a  = '0; s8_b  = '0; s8_cin  = 1'b0; s8_sub  = 1'b0; s8_or  = 1'b1;
        #12;
        check("reset_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("reset_S", S, 64'd0);
        check("reset_Cout", {63'd0, Cout}, 64'd0);
        check("reset_in_ready", {63'd0, In_Ready}, 64'd1);
`ifdef CSLA_FLAGS_EN
        check("reset_Zero", {63'd0, Zero}, 64'd0);
        check("reset_Ovf", {63'd0, Ovf}, 64'd0);
`endif
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Directed vectors back to back, no stall: exact latency
        exact_lat = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, va[k], vb[k], vc[k], vs[k], 1'b1);
            tick(acc);
        end
        drain();

        // Backpressure: 6 back-to-back transactions, output stalled 3 cycles
        exact_lat = 1'b0;
        i = 0; j = 0;
        ra = $urandom; rb = $urandom; rc = rbit(); rs = rbit();
        while (i < 6 && j < 30) begin
            drive(1'b1, ra, rb, rc, rs, !(j >= 4 && j <= 6));
            if (j >= 4 && j <= 6) begin
                #1;
                check("in_ready_stall", {63'd0, In_Ready}, 64'd0);
            end
            tick(acc);
            if (acc) begin
                i++;
                ra = $urandom; rb = $urandom; rc = rbit(); rs = rbit();
            end
            j++;
        end
        check("bp_all_accepted", i, 6);
        drain();

        // Random traffic with random stalls and bubbles
        for (int k = 0; k < 80; k++) begin
            drive(rbit() | rbit(), $urandom, $urandom, rbit(), rbit(), rbit() | rbit());
            tick(acc);
        end
        drain();

        // Reset mid-flight: two in flight, the first one sitting at the output
        drive(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
        tick(acc);
        drive(1'b1, 32'hDEADBEEF, 32'h00000001, 1'b1, 1'b1, 1'b0);
        tick(acc);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(acc);
        tick(acc);
        check("pre_reset_out_valid", {63'd0, Out_Valid}, 64'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("midreset_S", S, 64'd0);
        check("midreset_Cout", {63'd0, Cout}, 64'd0);
        check("midreset_in_ready", {63'd0, In_Ready}, 64'd1);
        sb.delete();
        head_seen = 1'b0;
        Rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) tick(acc);
        check("post_reset_no_output", {63'd0, Out_Valid}, 64'd0);

        // Other parametrisations
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run16(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        run8(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csla_pipe_adder.md
Name: csla_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 32-bit combinational CSLA.
- Operand width and carry-select block width are generics. One carry-select block is resolved per pipeline stage.
- Valid/ready handshake on input and output with backpressure. Runtime add/subtract mode.
- Sits between operand-producing datapath logic and downstream consumers that may stall.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be a multiple of BLK.
- BLK, 8, carry-select block width in bits. NBLK = WIDTH/BLK blocks, NBLK >= 1.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- In_Valid  input  1  operand set present.
- In_Ready  output  1  block can accept this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- Sub  input  1  0 = A+B+Cin; 1 = A-B-Cin.
- Out_Valid  output  1  result present.
- Out_Ready  input  1  consumer takes result this cycle.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry out; in sub mode 1 = no borrow.

Behaviour:
- One clock domain, clock Clk. Reset Rst_n is asynchronous and active-low.
- Reset, asynchronous on Rst_n low: all stage valid bits 0, Out_Valid=0, S=0, Cout=0, In_Ready=1. Release is synchronous to the next Clk edge.
- Operand conditioning: Bx = Sub ? ~B : B. Carry-in c0 = Sub ? ~Cin : Cin.
  - Add computes A + Bx + c0.
  - Sub computes A - B - Cin as two's complement.
- Arithmetic per block i (bits i*BLK+BLK-1 : i*BLK):
  - Two candidate sums are precomputed, one with block carry-in 0 and one with carry-in 1, each BLK+1 bits.
  - The candidate is selected by the carry-out of block i-1. Block 0 uses c0.
  - Cout is the carry-out of block NBLK-1.
  - Result is exact modulo 2^WIDTH with no saturation.
- Pipeline structure: NBLK register stages.
  - Stage 1 captures block 0 resolved, plus the remaining unresolved operands/candidates and the carry.
  - Stage k captures block k-1 resolved.
  - Stage NBLK drives S, Cout and Out_Valid.
- Latency:
  - A transaction accepted on edge n appears with Out_Valid=1 after edge n+NBLK-1. Example: WIDTH=32, BLK=8 gives 4 cycles.
  - Throughput is one result per cycle when there is no stall.
- Handshake:
  - Acceptance occurs when In_Valid & In_Ready. Output transfer occurs when Out_Valid & Out_Ready.
  - Global advance enable: en = Out_Ready | ~Out_Valid. In_Ready = en, combinational from Out_Ready and the Out_Valid register.
  - All stages shift only when en=1. Bubbles are not collapsed.
  - While en=0, S, Cout and Out_Valid are held stable.
- Boundary conditions:
  - In_Valid=0 while en=1 inserts a bubble: the stage-1 valid bit becomes 0.
  - Simultaneous output transfer and input acceptance in the same cycle is allowed with no loss.
  - A and B may change freely when In_Valid=0 or In_Ready=0. They are sampled only on acceptance.
  - Rst_n asserted mid-operation discards all in-flight transactions. No result is emitted for them after reset release.
  - NBLK=1 degenerates to a single registered stage with latency 1.
  - Sum overflow wraps modulo 2^WIDTH; the carry is reported on Cout.

Optional Feature:
- Macro: CSLA_FLAGS_EN.
- Defined: adds output ports Zero (1 bit) and Ovf (1 bit).
  - Both are registered in the output stage alongside S.
  - Zero = (S==0).
  - Ovf = signed overflow = carry into MSB XOR carry out of MSB.
  - Both reset to 0 and are held under stall like S.
- Undefined: the ports do not exist and no flag logic is synthesised. All other behaviour is identical.

Test Plan (WIDTH=32, BLK=8 unless noted):
- Reset values: Rst_n=0 -> Out_Valid=0, S=0, Cout=0, In_Ready=1.
- Addition with carry:
  - A=FFFF0000, B=0000FFFF, Cin=1, Sub=0, Out_Ready=1 -> S=00000000, Cout=1, 4 cycles after accept.
  - A=32'd2017701177, B=32'd1701853, Cin=0 -> S=785DA516, Cout=0.
  - A=FFABCEDC, B=EF821EDA, Cin=1 -> S=EF2DEDB7, Cout=1.
- Subtract: A=5, B=7, Cin=0, Sub=1 -> S=FFFFFFFE, Cout=0.
  - With CSLA_FLAGS_EN: Zero=0, Ovf=0.
  - A=80000000, B=1, Sub=1 -> S=7FFFFFFF, Ovf=1.
- Backpressure:
  - Stream 6 back-to-back transactions with Out_Ready=0 for 3 cycles mid-stream.
  - Required: In_Ready=0 during the stall, S held stable, all 6 results delivered in order, none lost or duplicated.
- Reset mid-flight: 2 transactions in flight, pulse Rst_n low asynchronously (between edges) -> Out_Valid drops to 0 immediately, no result for either after release.
- Parametrised builds:
  - WIDTH=16, BLK=4 with A=FFFF, B=0001, Cin=0 -> S=0000, Cout=1, latency 4.
  - WIDTH=8, BLK=8 with A=80, B=80 -> S=00, Cout=1, latency 1.
